mult_seq_ctrl: RTL

- Sequential multiply controller for the EXE stage of the pipelined CPU. It replaces the single-cycle array product with an iterative shift-add sequencer, 1 bit per cycle.
- Owns the architectural HI/LO registers and serves MULT/MULTU and MTHI/MTLO.
- Drives a ready/busy handshake so the pipeline stalls EXE while a multiply is in flight.
- Supports cancellation of an in-flight multiply on an exception flush.

---
 rtl/mult_seq_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
//   Sequential multiply controller for the EXE stage. It runs a shift-add
//   multiply at one multiplier bit per cycle, owns the architectural HI/LO
//   registers, and serves MULT/MULTU as well as MTHI/MTLO. It exposes a
//   ready/busy handshake so the pipeline can stall EXE while a multiply is in
//   progress. An exception/eret flush cancels the multiply.
//
// Ports
//   clk, resetn               rising-edge clock; asynchronous active-low reset
//   mult_valid, mult_signed   request strobe; 1 = MULT (signed), 0 = MULTU
//   mult_op1, mult_op2        rs / rt operands
//   mult_ready                high in IDLE; a request is accepted only then
//   mult_busy                 high in BUSY or DONE; stalls EXE
//   flush                     cancels any in-flight multiply; no HI/LO write
//   result_valid, product     one-cycle pulse in DONE with the final product
//   hi_we, lo_we, hilo_wdata  MTHI / MTLO write port
//   hi, lo                    architectural HI / LO
// -----------------------------------------------------------------------------
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               mult_valid,
  input  logic               mult_signed,
  input  logic [WIDTH-1:0]   mult_op1,
  input  logic [WIDTH-1:0]   mult_op2,
  output logic               mult_ready,
  output logic               mult_busy,
  input  logic               flush,
  output logic               result_valid,
  output logic [2*WIDTH-1:0] product,
  input  logic               hi_we,
  input  logic               lo_we,
  input  logic [WIDTH-1:0]   hilo_wdata,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic              neg_q, neg_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;

  logic [WIDTH-1:0]  op1_abs;
  logic [WIDTH-1:0]  op2_abs;
  logic [PW-1:0]     prod_w;
  logic              accept;

  // Magnitudes of the operands. For the most negative value the negation
  // wraps to itself, which is exactly 2^(WIDTH-1) read as unsigned.
  assign op1_abs = (mult_signed && mult_op1[WIDTH-1]) ? -mult_op1 : mult_op1;
  assign op2_abs = (mult_signed && mult_op2[WIDTH-1]) ? -mult_op2 : mult_op2;

  // Sign is reapplied to the unsigned accumulator only at the output.
  assign prod_w = neg_q ? -acc_q : acc_q;

  assign accept       = (state_q == S_IDLE) && mult_valid && !flush;
  assign mult_ready   = (state_q == S_IDLE);
  assign mult_busy    = (state_q != S_IDLE);
  assign result_valid = (state_q == S_DONE) && !flush;
  assign product      = prod_w;
  assign hi           = hi_q;
  assign lo           = lo_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (hi_we) hi_d = hilo_wdata;
    if (lo_we) lo_d = hilo_wdata;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_BUSY;
          mcand_d  = {{WIDTH{1'b0}}, op1_abs};
          mplier_d = op2_abs;
          neg_d    = mult_signed && (mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      S_BUSY: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        // The multiply commit is applied after the MTHI/MTLO writes so it
        // takes priority when both land on the same edge.
        if (!flush) begin
          hi_d = prod_w[PW-1:WIDTH];
          lo_d = prod_w[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A flush cancels whatever is in flight. It does not block MTHI/MTLO.
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule
